// File: rtl/mem_log_trig.sv
// Filter-sample logger: packs PACK samples per word into an internal BRAM,
// with valid qualification, decimation, and one-shot or circular pre/post-trigger capture.
module mem_log_trig #(
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int BRAM_DATA_WIDTH = 16,
  parameter int PACK            = 2,
  parameter int DECIM_WIDTH     = 8
) (
  input  logic                            clk,
  input  logic                            i_rst,
  input  logic [BRAM_DATA_WIDTH-1:0]      i_filter_data,
  input  logic                            i_valid,
  input  logic                            i_run_log,
  input  logic                            i_mode,
  input  logic                            i_trigger,
  input  logic [BRAM_ADDR_WIDTH-1:0]      i_post_count,
  input  logic [DECIM_WIDTH-1:0]          i_decim,
  input  logic                            i_read_log,
  input  logic [BRAM_ADDR_WIDTH-1:0]      i_addr_log_to_mem,
  output logic                            o_mem_full,
  output logic                            o_busy,
  output logic [BRAM_ADDR_WIDTH-1:0]      o_start_addr,
  output logic [PACK*BRAM_DATA_WIDTH-1:0] o_data_log_from_mem,
  output logic                            o_rd_valid
);
  localparam int DW    = BRAM_DATA_WIDTH;
  localparam int WW    = PACK * BRAM_DATA_WIDTH;
  localparam int LW    = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int DEPTH = 1 << BRAM_ADDR_WIDTH;
  localparam logic [LW-1:0] LAST_LANE = LW'(PACK - 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_POST, S_DONE, S_READ} state_t;

  state_t                     state;
  logic [BRAM_ADDR_WIDTH-1:0] wr_ptr;
  logic [LW-1:0]              lane;
  logic [WW-1:0]              pack_buf;
  logic [DECIM_WIDTH-1:0]     decim_cnt;
  logic [DECIM_WIDTH-1:0]     decim_r;
  logic                       mode_r;
  logic [BRAM_ADDR_WIDTH-1:0] post_cnt;
  logic [BRAM_ADDR_WIDTH-1:0] post_len;
  logic                       wrapped;
  logic [WW-1:0]              mem [DEPTH];

  logic                       capturing, accept, word_done, post_zero, wr_en;
  logic                       wrap_next, post_hit, mode0_end, finish;
  logic [BRAM_ADDR_WIDTH-1:0] ptr_after;
  logic [WW-1:0]              wdata;

  always_comb begin
    capturing = (state == S_RUN) || (state == S_POST);
    accept    = capturing && i_valid && (decim_cnt == '0);
    word_done = accept && (lane == LAST_LANE);
    // A zero-length post window ends the capture without committing a pending word.
    post_zero = (state == S_POST) && (post_len == '0);
    wr_en     = word_done && !post_zero;
    ptr_after = wr_en ? wr_ptr + 1'b1 : wr_ptr;
    wrap_next = wrapped || (wr_en && (wr_ptr == '1));
    post_hit  = (state == S_POST) && wr_en && (post_cnt + 1'b1 == post_len);
    mode0_end = (state == S_RUN) && !mode_r && wr_en && (wr_ptr == '1);
    finish    = mode0_end || post_zero || post_hit;
    wdata     = pack_buf;
    wdata[(PACK-1)*DW +: DW] = i_filter_data;
  end

  always_ff @(posedge clk) begin
    if (i_rst && wr_en) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!i_rst) begin
      state               <= S_IDLE;
      wr_ptr              <= '0;
      lane                <= '0;
      pack_buf            <= '0;
      decim_cnt           <= '0;
      decim_r             <= '0;
      mode_r              <= 1'b0;
      post_cnt            <= '0;
      post_len            <= '0;
      wrapped             <= 1'b0;
      o_mem_full          <= 1'b0;
      o_busy              <= 1'b0;
      o_start_addr        <= '0;
      o_data_log_from_mem <= '0;
      o_rd_valid          <= 1'b0;
    end else begin
      o_rd_valid <= 1'b0;
      case (state)
        S_IDLE, S_READ: begin
          if (i_run_log) begin
            state        <= S_RUN;
            mode_r       <= i_mode;
            decim_r      <= i_decim;
            wr_ptr       <= '0;
            lane         <= '0;
            decim_cnt    <= '0;
            post_cnt     <= '0;
            wrapped      <= 1'b0;
            o_mem_full   <= 1'b0;
            o_busy       <= 1'b1;
            o_start_addr <= '0;
          end else if (state == S_READ) begin
            o_data_log_from_mem <= mem[i_addr_log_to_mem];
            o_rd_valid          <= 1'b1;
          end
        end
        S_RUN, S_POST: begin
          if (i_valid) decim_cnt <= (decim_cnt == decim_r) ? '0 : decim_cnt + 1'b1;
          if (accept) begin
            if (word_done) begin
              lane <= '0;
            end else begin
              pack_buf[lane*DW +: DW] <= i_filter_data;
              lane <= lane + 1'b1;
            end
          end
          if (wr_en) begin
            wr_ptr  <= wr_ptr + 1'b1;
            wrapped <= wrap_next;
            if (state == S_POST) post_cnt <= post_cnt + 1'b1;
          end
          if (finish) begin
            state        <= S_DONE;
            o_busy       <= 1'b0;
            o_mem_full   <= 1'b1;
            o_start_addr <= (mode_r && wrap_next) ? ptr_after : '0;
          end else if ((state == S_RUN) && mode_r && i_trigger) begin
            state    <= S_POST;
            post_len <= i_post_count;
            post_cnt <= '0;
          end
        end
        S_DONE: begin
          if (i_read_log) state <= S_READ;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_log_trig.sv
// Bench for mem_log_trig: random captures in both modes checked against a
// sample-list model of the logger; BRAM contents verified through the read path.
module tb_mem_log_trig;
  localparam int AW = 4, DW = 16, PK = 2, DCW = 8, WW = PK * DW, DEPTH = 16;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          i_rst = 1'b0;
  logic [DW-1:0] i_filter_data = '0;
  logic          i_valid = 1'b0, i_run_log = 1'b0, i_mode = 1'b0, i_trigger = 1'b0;
  logic [AW-1:0] i_post_count = '0;
  logic [DCW-1:0] i_decim = '0;
  logic          i_read_log = 1'b0;
  logic [AW-1:0] i_addr_log_to_mem = '0;
  logic          o_mem_full, o_busy, o_rd_valid;
  logic [AW-1:0] o_start_addr;
  logic [WW-1:0] o_data_log_from_mem;

  mem_log_trig #(.BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW), .PACK(PK), .DECIM_WIDTH(DCW)) dut (
    .clk(clk), .i_rst(i_rst), .i_filter_data(i_filter_data), .i_valid(i_valid),
    .i_run_log(i_run_log), .i_mode(i_mode), .i_trigger(i_trigger), .i_post_count(i_post_count),
    .i_decim(i_decim), .i_read_log(i_read_log), .i_addr_log_to_mem(i_addr_log_to_mem),
    .o_mem_full(o_mem_full), .o_busy(o_busy), .o_start_addr(o_start_addr),
    .o_data_log_from_mem(o_data_log_from_mem), .o_rd_valid(o_rd_valid)
  );

  // scoreboard state
  int checks = 0, failures = 0;
  logic [WW-1:0] model_mem [DEPTH];
  logic [WW-1:0] exp_q[$];
  logic [DW-1:0] pend_q[$];
  int m_nwords, m_vcount;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_full"}, 32'(o_mem_full), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_start"}, 32'(o_start_addr), 0);
    chk({tag, "_data"}, 32'(o_data_log_from_mem), 0);
    chk({tag, "_rdv"}, 32'(o_rd_valid), 0);
  endtask

  // driver + model: one capture from IDLE/READ to DONE (or to a mid-run reset)
  task automatic capture(input bit mode, input int decim, input int vpct, input bit seq,
                         input int seq_base, input int trig_words, input int post,
                         input bit hold_pending, input int abort_cyc);
    bit in_post, trig_done, done_now, trig_now, v;
    int pcount, seqv, start;
    logic [DW-1:0] d;
    logic [WW-1:0] w;
    i_run_log = 1'b1; i_mode = mode; i_decim = DCW'(decim);
    i_post_count = AW'(post); i_addr_log_to_mem = AW'($urandom_range(DEPTH - 1));
    step();
    i_run_log = 1'b0;
    chk("start_busy", 32'(o_busy), 1);
    chk("start_full", 32'(o_mem_full), 0);
    chk("start_rdv", 32'(o_rd_valid), 0);
    // these must have been latched at start
    i_decim = DCW'($urandom); i_mode = 1'($urandom);
    m_nwords = 0; m_vcount = 0; pend_q.delete();
    in_post = 0; trig_done = 0; pcount = 0; seqv = seq_base; done_now = 0;
    for (int cyc = 0; cyc < 4000 && !done_now; cyc++) begin
      if (cyc == abort_cyc) begin
        i_valid = 1'b0; i_rst = 1'b0;
        step();
        i_rst = 1'b1;
        chk_reset("abort");
        return;
      end
      v = ($urandom_range(99) < vpct);
      trig_now = mode && !trig_done && (m_nwords >= trig_words);
      if (trig_now && hold_pending) begin
        if (pend_q.size() != 1) trig_now = 0;
        else v = 0;
      end
      if (seq) begin
        d = DW'(seqv);
        if (v) seqv++;
      end else begin
        d = DW'($urandom);
      end
      i_valid = v; i_filter_data = d;
      i_trigger = trig_now || ((!mode || in_post) && ($urandom_range(7) == 0));
      i_run_log = ($urandom_range(15) == 0);
      i_read_log = ($urandom_range(15) == 0);
      if (in_post) i_post_count = AW'($urandom);
      // reference model
      done_now = 0;
      if (in_post && post == 0) begin
        done_now = 1;
      end else begin
        if (v) begin
          if (m_vcount % (decim + 1) == 0) pend_q.push_back(d);
          m_vcount++;
        end
        if (pend_q.size() == PK) begin
          w = '0;
          for (int k = 0; k < PK; k++) w[k*DW +: DW] = pend_q[k];
          pend_q.delete();
          model_mem[m_nwords % DEPTH] = w;
          m_nwords++;
          if (!mode && m_nwords == DEPTH) done_now = 1;
          if (in_post) begin
            pcount++;
            if (pcount == post) done_now = 1;
          end
        end
      end
      if (trig_now) begin in_post = 1; trig_done = 1; end
      step();
      i_trigger = 1'b0; i_run_log = 1'b0; i_read_log = 1'b0; i_valid = 1'b0;
      chk("cap_full", 32'(o_mem_full), 32'(done_now));
      chk("cap_busy", 32'(o_busy), 32'(!done_now));
    end
    if (!done_now) chk("capture_timeout", 0, 1);
    start = (mode && m_nwords >= DEPTH) ? (m_nwords % DEPTH) : 0;
    chk("start_addr", 32'(o_start_addr), 32'(start));
  endtask

  task automatic readback();
    int off, a;
    // DONE ignores new run requests
    for (int i = 0; i < 2; i++) begin
      i_run_log = 1'($urandom);
      step();
      i_run_log = 1'b0;
      chk("done_full", 32'(o_mem_full), 1);
      chk("done_busy", 32'(o_busy), 0);
      chk("done_rdv", 32'(o_rd_valid), 0);
    end
    i_read_log = 1'b1;
    step();
    i_read_log = 1'b0;
    chk("read_enter_rdv", 32'(o_rd_valid), 0);
    chk("read_full", 32'(o_mem_full), 1);
    off = $urandom_range(DEPTH - 1);
    for (int i = 0; i < DEPTH; i++) begin
      a = (i * 7 + off) % DEPTH;
      i_addr_log_to_mem = AW'(a);
      exp_q.push_back(model_mem[a]);
      step();
      chk("rd_valid", 32'(o_rd_valid), 1);
      chk($sformatf("rd_data[%0d]", a), 32'(o_data_log_from_mem), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step();
    chk_reset("reset");
    i_rst = 1'b1;
    step();
    chk_reset("idle");

    // one-shot fill, samples 1..32 -> word k = {2k+2, 2k+1}
    capture(0, 0, 100, 1, 1, 0, 0, 0, -1);
    readback();
    // one-shot with decimation 2 on samples 0,1,2,...
    capture(0, 2, 100, 1, 0, 0, 0, 0, -1);
    readback();
    // gapped valid, same sample stream as the first run
    capture(0, 0, 50, 1, 1, 0, 0, 0, -1);
    readback();
    // gapped valid, random data and decimation
    capture(0, $urandom_range(1, 3), 60, 0, 0, 0, 0, 0, -1);
    readback();
    // circular: trigger after 40 words, 5 post words
    capture(1, 0, 100, 0, 0, 40, 5, 0, -1);
    chk("tp_start13", 32'(o_start_addr), 13);
    readback();
    // circular: random valid/decimation, short run without wrap
    capture(1, $urandom_range(1, 2), 70, 0, 0, 3, 2, 0, -1);
    readback();
    // circular: post count 0 with half-packed word pending
    capture(1, 0, 100, 0, 0, 20, 0, 1, -1);
    chk("tp_start4", 32'(o_start_addr), 4);
    readback();
    // reset during POST, then read request from IDLE must be ignored
    capture(1, 0, 100, 0, 0, 3, 9, 0, 14);
    i_read_log = 1'b1;
    step();
    i_read_log = 1'b0;
    chk_reset("idle_read");
    step();
    chk_reset("idle_hold");
    // restart after abort begins again at address 0
    capture(0, $urandom_range(0, 1), 80, 0, 0, 0, 0, 0, -1);
    readback();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_log_trig.md
# mem_log_trig

Parametrised successor of the filter-output BRAM logger: captures a stream of filter samples, packs PACK consecutive samples per memory word, and stores them in an internal BRAM of 2^BRAM_ADDR_WIDTH words. It adds sample-valid qualification, decimation and a circular pre/post-trigger capture mode on top of the one-shot fill mode. It sits between the filter output and the host/debug read path, which reads words back by address once capture is done.

## Interface
- BRAM_ADDR_WIDTH, 15, word address width; depth = 2^BRAM_ADDR_WIDTH words
- BRAM_DATA_WIDTH, 16, width of one filter sample
- PACK, 2, samples per memory word, legal 1..4; word width = PACK*BRAM_DATA_WIDTH
- DECIM_WIDTH, 8, width of decimation control
- clk  in  1  single clock, all logic on rising edge
- i_rst  in  1  synchronous, active-low reset
- i_filter_data  in  BRAM_DATA_WIDTH  filter sample
- i_valid  in  1  sample strobe; sample taken only when high
- i_run_log  in  1  start-capture pulse
- i_mode  in  1  0 = one-shot fill, 1 = circular with trigger
- i_trigger  in  1  stop trigger (circular mode only)
- i_post_count  in  BRAM_ADDR_WIDTH  words to write after trigger, sampled at trigger
- i_decim  in  DECIM_WIDTH  keep 1 of every i_decim+1 valid samples
- i_read_log  in  1  enter read state from DONE
- i_addr_log_to_mem  in  BRAM_ADDR_WIDTH  read word address
- o_mem_full  out  1  capture complete (DONE or READ)
- o_busy  out  1  capture in progress (RUN or POST)
- o_start_addr  out  BRAM_ADDR_WIDTH  address of oldest valid word
- o_data_log_from_mem  out  PACK*BRAM_DATA_WIDTH  read data
- o_rd_valid  out  1  o_data_log_from_mem updated this cycle

## Operation
- States: IDLE, RUN, POST, DONE, READ. Reset -> IDLE.
- IDLE/READ: i_run_log=1 -> RUN; i_mode, i_decim latched; wr_ptr, pack lane, decim counter, post counter cleared; o_mem_full cleared.
- RUN/POST: accepted sample = i_valid && decim counter == 0; decim counter counts valid samples modulo i_decim+1 (i_decim=0 keeps all).
- Packing: first accepted sample in lane 0 (bits BRAM_DATA_WIDTH-1:0), next in lane 1, etc.; word written to BRAM[wr_ptr] on the cycle the last lane is accepted; wr_ptr increments, wraps 2^BRAM_ADDR_WIDTH-1 -> 0.
- Mode 0: after the word at address 2^BRAM_ADDR_WIDTH-1 is written -> DONE; o_start_addr = 0. i_trigger ignored.
- Mode 1: RUN writes continuously with wrap. i_trigger=1 in RUN -> POST, latches i_post_count. POST counts words written in cycles after the trigger cycle; when count reaches post_count -> DONE. post_count = 0 -> DONE on the cycle after trigger. On entering DONE, o_start_addr = wr_ptr if memory has wrapped, else 0.
- Stopping discards any partially packed word.
- DONE: i_read_log=1 -> READ. READ: each cycle reads BRAM[i_addr_log_to_mem].
- i_run_log in RUN/POST/DONE ignored; i_read_log outside DONE ignored; i_trigger in POST ignored.

## Timing
- Reset values: o_mem_full 0, o_busy 0, o_start_addr 0, o_data_log_from_mem 0, o_rd_valid 0; state IDLE. Reset mid-capture aborts to IDLE; BRAM contents not cleared.
- i_run_log seen at edge N -> o_busy=1 after edge N; first sample eligible at edge N+1.
- i_valid and i_trigger in the same cycle: sample accepted and counted as pre-trigger.
- Write is the same edge the last lane is accepted; DONE (o_mem_full=1, o_busy=0) visible after the edge that writes the final word.
- Read latency 1 cycle: address presented at edge N in READ -> data and o_rd_valid=1 after edge N. o_rd_valid=0 outside READ; o_data_log_from_mem holds last value.
- Same-cycle i_run_log in READ: new capture wins, read not performed.

## Test plan
- Params ADDR=4, PACK=2, mode 0, i_decim=0, valid every cycle, samples 0x0001..0x0020 -> BRAM[k] = {2k+2, 2k+1}; o_mem_full=1 after 32 samples; o_start_addr=0; readback of all 16 words matches with 1-cycle latency.
- Mode 0, i_decim=2, samples 0..95 valid -> stored samples 0,3,6,...; word 0 = {3,0}; full after 96 valid samples.
- Mode 0, i_valid toggling 1/0 -> only valid samples packed; contents identical to gap-free run.
- Mode 1, ADDR=4, trigger after 40 words, i_post_count=5 -> DONE after 45 words total; o_start_addr=45 mod 16 = 13; BRAM[13..12 wrapped] holds words 29..44 in order.
- Mode 1, trigger with i_post_count=0 and half-packed word pending -> DONE next cycle, partial word not written, wr_ptr unchanged.
- i_rst=0 during POST -> all outputs reset values, IDLE; subsequent i_run_log restarts at wr_ptr 0; i_read_log in IDLE ignored.
